// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the sequencer state enum, the default register-index width and the x0 index.
package pipe_ctrl_pkg;

    localparam int unsigned REG_ADDR_W_DEF = 5;
    localparam int unsigned ZERO_REG       = 0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2,
        STEP     = 2'd3
    } state_e;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter with asynchronous active-high reset and no clear.
// Used for the optional pipeline performance counters (PIPE_CTRL_PERF_EN).
module pipe_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline sequencer: stage enables/flushes, PC select, memory wait and debug halt/step.
// Optional performance counters (stall_cycles, flush_events) exist only with PIPE_CTRL_PERF_EN defined.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [REG_ADDR_W-1:0] if_id_rs1,
    input  logic [REG_ADDR_W-1:0] if_id_rs2,
    input  logic                  id_ex_memread,
    input  logic [REG_ADDR_W-1:0] id_ex_rd,
    input  logic                  ex_mem_branch,
    input  logic                  ex_mem_zero,
    input  logic                  ex_mem_memread,
    input  logic                  ex_mem_memwrite,
    input  logic                  dmem_ready,
    input  logic                  dbg_halt_req,
    input  logic                  dbg_step,
    output logic                  dmem_req,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  mem_wb_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic                  pc_sel,
    output logic                  dbg_halted
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events
`endif
);

    state_e state_q;
    state_e state_d;

    logic mem;
    logic blocked;
    logic taken;
    logic load_use;
    logic advance;

    assign mem      = ex_mem_memread | ex_mem_memwrite;
    assign blocked  = mem & ~dmem_ready;
    assign taken    = ex_mem_branch & ex_mem_zero;
    assign load_use = id_ex_memread
                    & (id_ex_rd != REG_ADDR_W'(ZERO_REG))
                    & ((id_ex_rd == if_id_rs1) | (id_ex_rd == if_id_rs2));

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (blocked) begin
                    state_d = MEM_WAIT;
                end else if (dbg_halt_req && !mem) begin
                    state_d = HALTED;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d = dbg_halt_req ? HALTED : RUN;
                end
            end
            HALTED: begin
                if (!dbg_halt_req) begin
                    state_d = RUN;
                end else if (dbg_step) begin
                    state_d = STEP;
                end
            end
            STEP: begin
                state_d = blocked ? MEM_WAIT : HALTED;
            end
            default: state_d = RUN;
        endcase
    end

    // A halt request in RUN freezes the cycle only when no access is in flight.
    always_comb begin
        advance = 1'b0;
        unique case (state_q)
            RUN:      advance = !blocked && !(dbg_halt_req && !mem);
            MEM_WAIT: advance = dmem_ready;
            STEP:     advance = !blocked;
            default:  advance = 1'b0;
        endcase
    end

    always_comb begin
        dmem_req     = 1'b0;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pc_sel       = 1'b0;
        if (!arst) begin
            dmem_req = mem && (state_q != HALTED);
            if (advance) begin
                id_ex_en  = 1'b1;
                ex_mem_en = 1'b1;
                mem_wb_en = 1'b1;
                if (taken) begin
                    pc_en        = 1'b1;
                    if_id_en     = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                    pc_sel       = 1'b1;
                end else if (load_use) begin
                    id_ex_flush = 1'b1;
                end else begin
                    pc_en    = 1'b1;
                    if_id_en = 1'b1;
                end
            end
        end
    end

    assign dbg_halted = (state_q == HALTED);

`ifdef PIPE_CTRL_PERF_EN
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = !arst && !pc_en && (state_q != HALTED);
    assign flush_inc = pc_sel;

    pipe_perf_cnt #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .arst  (arst),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    pipe_perf_cnt #(
        .CNT_W(CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .arst  (arst),
        .inc   (flush_inc),
        .count (flush_events)
    );
`endif

endmodule
